bomb_scheduler: RTL and testbench

- Owns the pool of bomb slots (default 6) shared by both players.
- Arbitrates placement requests from P1 and P2, runs each slot's fuse and blast timers from the 60 Hz frame tick, and reports explosion events.
- Presents a read port indexed by the control FSM's bomb_id so the DRAW_BOMB / DRAW_EXPLOSION states can fetch slot contents.

---
 rtl/bomberman_pkg.sv | 29 ++
 rtl/bomb_slot.sv | 107 ++++++++++
 rtl/bomb_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_bomb_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and widths for the bomb scheduling logic.
// BLAST_RANGE and in_blast_reach() are only used when CHAIN_REACTION_EN is defined.
package bomberman_pkg;

    localparam int SLOT_IDX_W  = 3;
    localparam int TILE_W      = 4;
    localparam int TIMER_W     = 8;
    localparam int BLAST_RANGE = 2;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FUSE  = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_state_t;

    // True when tile b lies in the same row or column as tile a within BLAST_RANGE.
    function automatic logic in_blast_reach(input logic [TILE_W-1:0] ax,
                                            input logic [TILE_W-1:0] ay,
                                            input logic [TILE_W-1:0] bx,
                                            input logic [TILE_W-1:0] by);
        logic [TILE_W-1:0] dx;
        logic [TILE_W-1:0] dy;
        dx = (ax > bx) ? (ax - bx) : (bx - ax);
        dy = (ay > by) ? (ay - by) : (by - ay);
        return ((ay == by) && (dx <= TILE_W'(BLAST_RANGE))) ||
               ((ax == bx) && (dy <= TILE_W'(BLAST_RANGE)));
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> BLAST -> IDLE, with its own tick-driven timer.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int FUSE_TICKS  = 180,
    parameter int BLAST_TICKS = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              tick_en,
    input  logic              grant,
    input  logic              force_one,
    input  logic [TILE_W-1:0] grant_x,
    input  logic [TILE_W-1:0] grant_y,
    input  logic              grant_owner,
    output slot_state_t       state,
    output logic [TILE_W-1:0] tile_x,
    output logic [TILE_W-1:0] tile_y,
    output logic              owner,
    output logic              blast_pulse
);

    slot_state_t        state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [TILE_W-1:0]  tile_x_next;
    logic [TILE_W-1:0]  tile_y_next;
    logic               owner_next;
    logic               pulse_next;

    // A forced fuse takes precedence over a coincident tick so the chained bomb
    // still waits for the following tick before exploding.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        tile_x_next = tile_x;
        tile_y_next = tile_y;
        owner_next  = owner;
        pulse_next  = 1'b0;
        if (clear) begin
            state_next  = SLOT_IDLE;
            timer_next  = '0;
            tile_x_next = '0;
            tile_y_next = '0;
            owner_next  = 1'b0;
        end else begin
            case (state)
                SLOT_IDLE: begin
                    if (grant) begin
                        state_next  = SLOT_FUSE;
                        timer_next  = TIMER_W'(FUSE_TICKS);
                        tile_x_next = grant_x;
                        tile_y_next = grant_y;
                        owner_next  = grant_owner;
                    end
                end
                SLOT_FUSE: begin
                    if (force_one) begin
                        timer_next = TIMER_W'(1);
                    end else if (tick_en) begin
                        if (timer == TIMER_W'(1)) begin
                            state_next = SLOT_BLAST;
                            timer_next = TIMER_W'(BLAST_TICKS);
                            pulse_next = 1'b1;
                        end else begin
                            timer_next = timer - TIMER_W'(1);
                        end
                    end
                end
                SLOT_BLAST: begin
                    if (tick_en) begin
                        if (timer == TIMER_W'(1)) begin
                            state_next = SLOT_IDLE;
                            timer_next = '0;
                        end else begin
                            timer_next = timer - TIMER_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = SLOT_IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= SLOT_IDLE;
            timer       <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            owner       <= 1'b0;
            blast_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            tile_x      <= tile_x_next;
            tile_y      <= tile_y_next;
            owner       <= owner_next;
            blast_pulse <= pulse_next;
        end
    end

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb slot pool: arbitrates P1/P2 placements, runs slot timers, exposes a read port.
// Define CHAIN_REACTION_EN to let a new blast force nearby fuses to explode on the next tick.
module bomb_scheduler
    import bomberman_pkg::*;
#(
    parameter int NUM_BOMBS      = 6,
    parameter int FUSE_TICKS     = 180,
    parameter int BLAST_TICKS    = 30,
    parameter int MAX_PER_PLAYER = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  p1_place,
    input  logic                  p2_place,
    input  logic [TILE_W-1:0]     p1_tile_x,
    input  logic [TILE_W-1:0]     p1_tile_y,
    input  logic [TILE_W-1:0]     p2_tile_x,
    input  logic [TILE_W-1:0]     p2_tile_y,
    output logic                  p1_ack,
    output logic                  p1_nack,
    output logic                  p2_ack,
    output logic                  p2_nack,
    input  logic [SLOT_IDX_W-1:0] rd_id,
    output logic                  rd_active,
    output logic                  rd_exploding,
    output logic                  rd_owner,
    output logic [TILE_W-1:0]     rd_tile_x,
    output logic [TILE_W-1:0]     rd_tile_y,
    output logic [NUM_BOMBS-1:0]  blast_mask,
    output logic [1:0]            p1_count,
    output logic [1:0]            p2_count
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_PER_PLAYER);

    slot_state_t       slot_state  [NUM_BOMBS];
    logic [TILE_W-1:0] slot_x      [NUM_BOMBS];
    logic [TILE_W-1:0] slot_y      [NUM_BOMBS];
    logic              slot_owner  [NUM_BOMBS];
    logic [TILE_W-1:0] grant_x     [NUM_BOMBS];
    logic [TILE_W-1:0] grant_y     [NUM_BOMBS];
    logic              grant_owner [NUM_BOMBS];
    logic [NUM_BOMBS-1:0] slot_grant;
    logic [NUM_BOMBS-1:0] force_vec;

    logic [1:0]            p1_cnt, p2_cnt;
    logic                  have_idle0, have_idle1;
    logic [SLOT_IDX_W-1:0] idle0, idle1;
    logic                  p1_tile_live, p2_tile_live;
    logic                  p1_ok, p2_ok, same_tile;
    logic                  grant1, grant2, flip;
    logic [SLOT_IDX_W-1:0] slot1, slot2;
    logic                  prio_p2;

    // Occupancy summary of the registered slot state: counts, free slots, tile clashes.
    always_comb begin
        p1_cnt       = '0;
        p2_cnt       = '0;
        have_idle0   = 1'b0;
        have_idle1   = 1'b0;
        idle0        = '0;
        idle1        = '0;
        p1_tile_live = 1'b0;
        p2_tile_live = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (slot_state[i] == SLOT_IDLE) begin
                if (!have_idle0) begin
                    have_idle0 = 1'b1;
                    idle0      = SLOT_IDX_W'(i);
                end else if (!have_idle1) begin
                    have_idle1 = 1'b1;
                    idle1      = SLOT_IDX_W'(i);
                end
            end else begin
                if (slot_owner[i]) p2_cnt = p2_cnt + 2'd1;
                else               p1_cnt = p1_cnt + 2'd1;
                if (slot_x[i] == p1_tile_x && slot_y[i] == p1_tile_y) p1_tile_live = 1'b1;
                if (slot_x[i] == p2_tile_x && slot_y[i] == p2_tile_y) p2_tile_live = 1'b1;
            end
        end
    end

    // Two acceptable requests share the pool unless they collide on tile or free slots.
    always_comb begin
        p1_ok     = p1_place && enable && (p1_cnt < MAX_CNT) && !p1_tile_live && have_idle0;
        p2_ok     = p2_place && enable && (p2_cnt < MAX_CNT) && !p2_tile_live && have_idle0;
        same_tile = (p1_tile_x == p2_tile_x) && (p1_tile_y == p2_tile_y);
        grant1    = 1'b0;
        grant2    = 1'b0;
        slot1     = idle0;
        slot2     = idle0;
        flip      = 1'b0;
        if (p1_ok && p2_ok) begin
            if (!same_tile && have_idle1) begin
                grant1 = 1'b1;
                grant2 = 1'b1;
                if (prio_p2) slot1 = idle1;
                else         slot2 = idle1;
            end else begin
                flip = 1'b1;
                if (prio_p2) grant2 = 1'b1;
                else         grant1 = 1'b1;
            end
        end else begin
            grant1 = p1_ok;
            grant2 = p2_ok;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BOMBS; i++) begin
            slot_grant[i]  = (grant1 && slot1 == SLOT_IDX_W'(i)) ||
                             (grant2 && slot2 == SLOT_IDX_W'(i));
            grant_owner[i] = !(grant1 && slot1 == SLOT_IDX_W'(i));
            grant_x[i]     = grant_owner[i] ? p2_tile_x : p1_tile_x;
            grant_y[i]     = grant_owner[i] ? p2_tile_y : p1_tile_y;
        end
    end

`ifdef CHAIN_REACTION_EN
    // Slots that blasted last edge still hold their tile, so reach is measured from there.
    always_comb begin
        force_vec = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            for (int j = 0; j < NUM_BOMBS; j++) begin
                if (slot_state[i] == SLOT_FUSE && blast_mask[j] &&
                    in_blast_reach(slot_x[j], slot_y[j], slot_x[i], slot_y[i])) begin
                    force_vec[i] = 1'b1;
                end
            end
        end
    end
`else
    assign force_vec = '0;
`endif

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS (FUSE_TICKS),
            .BLAST_TICKS(BLAST_TICKS)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .tick_en    (tick && enable),
            .grant      (slot_grant[g]),
            .force_one  (force_vec[g]),
            .grant_x    (grant_x[g]),
            .grant_y    (grant_y[g]),
            .grant_owner(grant_owner[g]),
            .state      (slot_state[g]),
            .tile_x     (slot_x[g]),
            .tile_y     (slot_y[g]),
            .owner      (slot_owner[g]),
            .blast_pulse(blast_mask[g])
        );
    end

    // A clear on the request cycle suppresses both ack and nack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p1_ack  <= 1'b0;
            p1_nack <= 1'b0;
            p2_ack  <= 1'b0;
            p2_nack <= 1'b0;
            prio_p2 <= 1'b0;
        end else if (clear) begin
            p1_ack  <= 1'b0;
            p1_nack <= 1'b0;
            p2_ack  <= 1'b0;
            p2_nack <= 1'b0;
            prio_p2 <= 1'b0;
        end else begin
            p1_ack  <= grant1;
            p1_nack <= p1_place && !grant1;
            p2_ack  <= grant2;
            p2_nack <= p2_place && !grant2;
            if (flip) prio_p2 <= !prio_p2;
        end
    end

    always_comb begin
        rd_active    = 1'b0;
        rd_exploding = 1'b0;
        rd_owner     = 1'b0;
        rd_tile_x    = '0;
        rd_tile_y    = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (rd_id == SLOT_IDX_W'(i)) begin
                rd_active    = (slot_state[i] != SLOT_IDLE);
                rd_exploding = (slot_state[i] == SLOT_BLAST);
                rd_owner     = slot_owner[i];
                rd_tile_x    = slot_x[i];
                rd_tile_y    = slot_y[i];
            end
        end
    end

    assign p1_count = p1_cnt;
    assign p2_count = p2_cnt;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Randomized and directed bench for bomb_scheduler against a per-bomb reference model.
// Honours CHAIN_REACTION_EN the same way the design does.
module tb_bomb_scheduler;

    localparam int NB    = 6;
    localparam int FUSE  = 180;
    localparam int BLAST = 30;
    localparam int MAXP  = 3;
    localparam int RANGE = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, enable = 1'b0, clear = 1'b0;
    logic       p1_place = 1'b0, p2_place = 1'b0;
    logic [3:0] p1_tile_x = '0, p1_tile_y = '0, p2_tile_x = '0, p2_tile_y = '0;
    logic [2:0] rd_id = '0;
    logic       p1_ack, p1_nack, p2_ack, p2_nack;
    logic       rd_active, rd_exploding, rd_owner;
    logic [3:0] rd_tile_x, rd_tile_y;
    logic [5:0] blast_mask;
    logic [1:0] p1_count, p2_count;

    bomb_scheduler dut (
        .clock(clock), .reset(reset), .tick(tick), .enable(enable), .clear(clear),
        .p1_place(p1_place), .p2_place(p2_place),
        .p1_tile_x(p1_tile_x), .p1_tile_y(p1_tile_y),
        .p2_tile_x(p2_tile_x), .p2_tile_y(p2_tile_y),
        .p1_ack(p1_ack), .p1_nack(p1_nack), .p2_ack(p2_ack), .p2_nack(p2_nack),
        .rd_id(rd_id), .rd_active(rd_active), .rd_exploding(rd_exploding),
        .rd_owner(rd_owner), .rd_tile_x(rd_tile_x), .rd_tile_y(rd_tile_y),
        .blast_mask(blast_mask), .p1_count(p1_count), .p2_count(p2_count)
    );

    always #10 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 fuse, 2 blast; ticks_left counts remaining ticks in the phase.
    int m_phase [NB];
    int m_left  [NB];
    int m_x     [NB];
    int m_y     [NB];
    int m_own   [NB];
    int e_p1_ack = 0, e_p1_nack = 0, e_p2_ack = 0, e_p2_nack = 0, e_mask = 0;
    int m_prio = 0;
    int tick_count = 0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int live_count(input int p);
        int n = 0;
        for (int i = 0; i < NB; i++) if (m_phase[i] != 0 && m_own[i] == p) n++;
        return n;
    endfunction

    function automatic bit tile_taken(input int x, input int y);
        for (int i = 0; i < NB; i++) if (m_phase[i] != 0 && m_x[i] == x && m_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit near(input int ax, input int ay, input int bx, input int by);
        int d;
        if (ay == by) begin
            d = ax - bx;
            if (d < 0) d = -d;
            if (d <= RANGE) return 1'b1;
        end
        if (ax == bx) begin
            d = ay - by;
            if (d < 0) d = -d;
            if (d <= RANGE) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic compare_model();
        check_output("p1_ack", p1_ack, e_p1_ack);
        check_output("p1_nack", p1_nack, e_p1_nack);
        check_output("p2_ack", p2_ack, e_p2_ack);
        check_output("p2_nack", p2_nack, e_p2_nack);
        check_output("blast_mask", blast_mask, e_mask);
        check_output("p1_count", p1_count, live_count(0));
        check_output("p2_count", p2_count, live_count(1));
        if (int'(rd_id) < NB) begin
            check_output("rd_active", rd_active, m_phase[rd_id] != 0);
            check_output("rd_exploding", rd_exploding, m_phase[rd_id] == 2);
            if (m_phase[rd_id] != 0) begin
                check_output("rd_owner", rd_owner, m_own[rd_id]);
                check_output("rd_tile_x", rd_tile_x, m_x[rd_id]);
                check_output("rd_tile_y", rd_tile_y, m_y[rd_id]);
            end
        end else begin
            check_output("rd_out_of_range", {rd_active, rd_exploding, rd_owner, rd_tile_x, rd_tile_y}, 0);
        end
    endtask

    task automatic model_update();
        int  free_q[$];
        bit  ok1, ok2, g1, g2, flip;
        int  s1, s2, new_mask;
        bit  forced [NB];
        bit  ticking;
        if (clear) begin
            for (int i = 0; i < NB; i++) begin
                m_phase[i] = 0; m_left[i] = 0;
            end
            e_p1_ack = 0; e_p1_nack = 0; e_p2_ack = 0; e_p2_nack = 0;
            e_mask = 0; m_prio = 0;
            return;
        end
        for (int i = 0; i < NB; i++) if (m_phase[i] == 0) free_q.push_back(i);
        ok1 = p1_place && enable && live_count(0) < MAXP &&
              !tile_taken(p1_tile_x, p1_tile_y) && free_q.size() > 0;
        ok2 = p2_place && enable && live_count(1) < MAXP &&
              !tile_taken(p2_tile_x, p2_tile_y) && free_q.size() > 0;
        g1 = 0; g2 = 0; flip = 0; s1 = 0; s2 = 0;
        if (ok1 && ok2) begin
            if ((p1_tile_x != p2_tile_x || p1_tile_y != p2_tile_y) && free_q.size() >= 2) begin
                g1 = 1; g2 = 1;
                s1 = (m_prio == 0) ? free_q[0] : free_q[1];
                s2 = (m_prio == 0) ? free_q[1] : free_q[0];
            end else begin
                flip = 1;
                if (m_prio == 0) begin g1 = 1; s1 = free_q[0]; end
                else             begin g2 = 1; s2 = free_q[0]; end
            end
        end else if (ok1) begin
            g1 = 1; s1 = free_q[0];
        end else if (ok2) begin
            g2 = 1; s2 = free_q[0];
        end
        for (int i = 0; i < NB; i++) begin
            forced[i] = 1'b0;
`ifdef CHAIN_REACTION_EN
            if (m_phase[i] == 1)
                for (int j = 0; j < NB; j++)
                    if (e_mask[j] && near(m_x[j], m_y[j], m_x[i], m_y[i])) forced[i] = 1'b1;
`endif
        end
        ticking = tick && enable;
        if (ticking) tick_count++;
        new_mask = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_phase[i] == 1 && forced[i]) begin
                m_left[i] = 1;
            end else if (m_phase[i] != 0 && ticking) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_phase[i] == 1) begin
                        m_phase[i] = 2; m_left[i] = BLAST; new_mask |= (1 << i);
                    end else begin
                        m_phase[i] = 0;
                    end
                end
            end
        end
        if (g1) begin
            m_phase[s1] = 1; m_left[s1] = FUSE; m_x[s1] = p1_tile_x; m_y[s1] = p1_tile_y; m_own[s1] = 0;
        end
        if (g2) begin
            m_phase[s2] = 1; m_left[s2] = FUSE; m_x[s2] = p2_tile_x; m_y[s2] = p2_tile_y; m_own[s2] = 1;
        end
        e_p1_ack = g1; e_p1_nack = p1_place && !g1;
        e_p2_ack = g2; e_p2_nack = p2_place && !g2;
        e_mask = new_mask;
        if (flip) m_prio = 1 - m_prio;
    endtask

    task automatic cycle();
        @(negedge clock);
        compare_model();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic pl1, input int x1, input int y1,
                                  input logic pl2, input int x2, input int y2,
                                  input logic tk);
        p1_place = pl1; p1_tile_x = 4'(x1); p1_tile_y = 4'(y1);
        p2_place = pl2; p2_tile_x = 4'(x2); p2_tile_y = 4'(y2);
        tick = tk;
        cycle();
        p1_place = 1'b0; p2_place = 1'b0; tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) apply_stimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        apply_stimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NB; i++) begin
            m_phase[i] = 0; m_left[i] = 0; m_x[i] = 0; m_y[i] = 0; m_own[i] = 0;
        end
        #25;
        check_output("reset_outputs", {p1_ack, p1_nack, p2_ack, p2_nack, blast_mask, p1_count, p2_count}, 0);
        #10;
        reset = 1'b1;
        enable = 1'b1;
        @(posedge clock);
        #1;

        // Single bomb lifecycle.
        rd_id = 3'd0;
        apply_stimulus(1'b1, 3, 4, 1'b0, 0, 0, 1'b0);
        check_output("place_ack", p1_ack, 1);
        check_output("place_count", p1_count, 1);
        check_output("place_active", rd_active, 1);
        run_ticks(179);
        check_output("fuse_not_yet", blast_mask, 0);
        run_ticks(1);
        check_output("blast_pulse", blast_mask, 6'b000001);
        check_output("blast_exploding", rd_exploding, 1);
        run_ticks(30);
        check_output("blast_done_active", rd_active, 0);
        check_output("blast_done_count", p1_count, 0);

        // Same-tile conflicts alternate priority.
        apply_stimulus(1'b1, 5, 5, 1'b1, 5, 5, 1'b0);
        check_output("conflict1_p1_ack", p1_ack, 1);
        check_output("conflict1_p2_nack", p2_nack, 1);
        apply_stimulus(1'b1, 6, 6, 1'b1, 6, 6, 1'b0);
        check_output("conflict2_p2_ack", p2_ack, 1);
        check_output("conflict2_p1_nack", p1_nack, 1);
        do_clear();

        // Per-player limit and full pool.
        for (int k = 0; k < 4; k++) apply_stimulus(1'b1, k, 1, 1'b0, 0, 0, 1'b0);
        check_output("limit_fourth_nack", p1_nack, 1);
        check_output("limit_count", p1_count, 3);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 0, 0, 1'b1, k, 9, 1'b0);
        rd_id = 3'd5;
        #1;
        check_output("p2_slot5_owner", rd_owner, 1);
        apply_stimulus(1'b0, 0, 0, 1'b1, 12, 12, 1'b0);
        check_output("pool_full_nack", p2_nack, 1);
        do_clear();

        // Occupied tile is refused until its bomb is gone.
        rd_id = 3'd0;
        apply_stimulus(1'b1, 7, 7, 1'b0, 0, 0, 1'b0);
        apply_stimulus(1'b0, 0, 0, 1'b1, 7, 7, 1'b0);
        check_output("tile_busy_nack", p2_nack, 1);
        run_ticks(FUSE + BLAST);
        apply_stimulus(1'b0, 0, 0, 1'b1, 7, 7, 1'b0);
        check_output("tile_free_ack", p2_ack, 1);

        // Clear mid-fuse with a request in flight.
        run_ticks(10);
        clear = 1'b1;
        apply_stimulus(1'b1, 9, 9, 1'b0, 0, 0, 1'b1);
        clear = 1'b0;
        check_output("clear_no_pulse", {p1_ack, p1_nack, p2_ack, p2_nack}, 0);
        check_output("clear_counts", {p1_count, p2_count}, 0);
        for (int k = 0; k < NB; k++) begin
            rd_id = 3'(k);
            #1;
            check_output("clear_inactive", rd_active, 0);
        end

        // Neighbouring bombs: chained or independent explosions.
        begin
            int t_a, t_b, budget;
            t_a = -1; t_b = -1; budget = 0;
            rd_id = 3'd1;
            apply_stimulus(1'b1, 2, 2, 1'b0, 0, 0, 1'b0);
            run_ticks(20);
            apply_stimulus(1'b0, 0, 0, 1'b1, 2, 4, 1'b0);
            while ((t_a < 0 || t_b < 0) && budget < 400) begin
                run_ticks(1);
                if (blast_mask[0]) t_a = tick_count;
                if (blast_mask[1]) t_b = tick_count;
                budget++;
            end
`ifdef CHAIN_REACTION_EN
            check_output("chain_gap", t_b - t_a, 2);
`else
            check_output("independent_gap", t_b - t_a, 20);
`endif
        end
        do_clear();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rd_id  = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 399) == 0);
            apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3) != 0);
            clear = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
